// File: rtl/rng_pkg.sv
// Shared constants and helpers for the per-neuron Fibonacci LFSR random source.
package rng_pkg;

    localparam int RNG_MIN_WIDTH = 32'sd4;
    localparam int RNG_MAX_WIDTH = 32'sd32;

    // Maximal-length tap masks: bit i set means state[i] feeds the XOR.
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] mask;
        case (width)
            32'sd4:  mask = 32'h0000_000C;
            32'sd5:  mask = 32'h0000_0014;
            32'sd6:  mask = 32'h0000_0030;
            32'sd7:  mask = 32'h0000_0060;
            32'sd8:  mask = 32'h0000_00B8;
            32'sd9:  mask = 32'h0000_0110;
            32'sd10: mask = 32'h0000_0240;
            32'sd11: mask = 32'h0000_0500;
            32'sd12: mask = 32'h0000_0829;
            32'sd13: mask = 32'h0000_100D;
            32'sd14: mask = 32'h0000_2015;
            32'sd15: mask = 32'h0000_6000;
            32'sd16: mask = 32'h0000_D008;
            32'sd17: mask = 32'h0001_2000;
            32'sd18: mask = 32'h0002_0400;
            32'sd19: mask = 32'h0004_0023;
            32'sd20: mask = 32'h0009_0000;
            32'sd21: mask = 32'h0014_0000;
            32'sd22: mask = 32'h0030_0000;
            32'sd23: mask = 32'h0042_0000;
            32'sd24: mask = 32'h00E1_0000;
            32'sd25: mask = 32'h0120_0000;
            32'sd26: mask = 32'h0200_0023;
            32'sd27: mask = 32'h0400_0013;
            32'sd28: mask = 32'h0900_0000;
            32'sd29: mask = 32'h1400_0000;
            32'sd30: mask = 32'h2000_0029;
            32'sd31: mask = 32'h4800_0000;
            32'sd32: mask = 32'h8020_0003;
            default: mask = 32'h0000_0000;
        endcase
        return mask;
    endfunction

    // Shift left, new feedback bit enters at bit 0; bits above the LFSR width are don't-care.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic [31:0] mask);
        return {state[30:0], ^(state & mask)};
    endfunction

endpackage

// File: rtl/rng_lfsr_step.sv
// Combinational single-step advance of a WIDTH-bit Fibonacci LFSR.
module rng_lfsr_step
    import rng_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next
);

    localparam logic [31:0] MASK = lfsr_taps(WIDTH);

    assign next = WIDTH'(lfsr_next(32'(state), MASK));

endmodule

// File: rtl/random_generator.sv
// Per-neuron pseudo-random source: seeded maximal-length LFSR with registered output.
// Optional input port enable is added when the macro RNG_ENABLE_EN is defined.
module random_generator
    import rng_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
`ifdef RNG_ENABLE_EN
    input  logic             enable,
`endif
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] random_value
);

    generate
        if (WIDTH < RNG_MIN_WIDTH || WIDTH > RNG_MAX_WIDTH) begin : g_bad_width
            $error("random_generator: WIDTH %0d outside legal range 4..32", WIDTH);
        end
    endgenerate

    logic [WIDTH-1:0] state_r;
    logic             seeded_r;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] load_s;
    logic             advance_s;

`ifdef RNG_ENABLE_EN
    assign advance_s = enable;
`else
    assign advance_s = 1'b1;
`endif

    rng_lfsr_step #(.WIDTH(WIDTH)) u_step (
        .state (state_r),
        .next  (next_s)
    );

    // Zero seed would lock the LFSR, so substitute all-ones.
    always_comb begin
        load_s = seed;
        if (seed == {WIDTH{1'b0}}) begin
            load_s = {WIDTH{1'b1}};
        end else begin
            load_s = seed;
        end
    end

    // State register: seed load on first active edge, then one advance per active edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= {WIDTH{1'b0}};
            seeded_r <= 1'b0;
        end else if (advance_s) begin
            if (!seeded_r) begin
                state_r  <= load_s;
                seeded_r <= 1'b1;
            end else begin
                state_r  <= next_s;
            end
        end
    end

    assign random_value = state_r;

endmodule

// File: tb/tb_random_generator.sv
// Self-checking bench for random_generator (WIDTH=8) with an expected-value queue.
module tb_random_generator;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] seed  = 8'h01;
    logic [7:0] random_value;
`ifdef RNG_ENABLE_EN
    logic       enable = 1'b1;
`endif

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] m_state  = 8'h00;
    logic       m_seeded = 1'b0;

    random_generator #(.WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
`ifdef RNG_ENABLE_EN
        .enable       (enable),
`endif
        .seed         (seed),
        .random_value (random_value)
    );

    always #5 clock = ~clock;

    // Reference step: taps at bits 7,5,4,3, feedback shifted into bit 0.
    function automatic logic [7:0] ref_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Predict the next edge from the current inputs, then compare after that edge.
    task automatic tick_check(input string tag);
        logic act;
        act = 1'b1;
`ifdef RNG_ENABLE_EN
        act = enable;
`endif
        if (reset) begin
            m_state  = 8'h00;
            m_seeded = 1'b0;
        end else if (act) begin
            if (!m_seeded) begin
                m_state  = (seed == 8'h00) ? 8'hFF : seed;
                m_seeded = 1'b1;
            end else begin
                m_state = ref_next(m_state);
            end
        end
        exp_q.push_back(m_state);
        @(posedge clock);
        @(negedge clock);
        check_value(tag, random_value, exp_q.pop_front());
    endtask

    logic [7:0] seq1 [7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};
    logic [7:0] seq4 [3] = '{8'h01, 8'h02, 8'h04};

    initial begin
        bit seen [256];
        int distinct;
        bit zero_seen;
        bit early;

        // Reset state
        @(negedge clock);
        tick_check("reset_state");
        check_value("reset_zero", random_value, 8'h00);

        // Test 1: seed 01
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick_check("t1_model");
            check_value("t1_seq", random_value, seq1[i]);
        end

        // Test 2: zero seed substitution
        reset = 1'b1;
        seed  = 8'h00;
        tick_check("t2_reset");
        reset = 1'b0;
        tick_check("t2_first");
        check_value("t2_ff", random_value, 8'hFF);
        tick_check("t2_second");
        check_value("t2_fe", random_value, 8'hFE);
        zero_seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick_check("t2_run");
            if (random_value == 8'h00) zero_seen = 1'b1;
        end
        check_value("t2_never_zero", zero_seen, 1'b0);

        // Test 3: full period from seed 5A
        reset = 1'b1;
        seed  = 8'h5A;
        tick_check("t3_reset");
        reset = 1'b0;
        tick_check("t3_seed");
        check_value("t3_seed_val", random_value, 8'h5A);
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        distinct = 0;
        early    = 1'b0;
        for (int k = 1; k <= 255; k++) begin
            tick_check("t3_run");
            if (!seen[random_value]) distinct++;
            seen[random_value] = 1'b1;
            if (k < 255 && random_value == 8'h5A) early = 1'b1;
        end
        check_value("t3_wrap", random_value, 8'h5A);
        check_value("t3_not_early", early, 1'b0);
        check_value("t3_distinct", distinct, 255);
        check_value("t3_no_zero", seen[0], 1'b0);

        // Test 4: asynchronous reset between edges
        tick_check("t4_pre");
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_value("t4_async_clear", random_value, 8'h00);
        m_state  = 8'h00;
        m_seeded = 1'b0;
        @(negedge clock);
        seed  = 8'h01;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_check("t4_model");
            check_value("t4_restart", random_value, seq4[i]);
        end

        // Test 5: seed changes after seeding are ignored
        seed = 8'h77;
        tick_check("t5_model");
        check_value("t5_ignore_a", random_value, 8'h08);
        tick_check("t5_model");
        check_value("t5_ignore_b", random_value, 8'h11);

`ifdef RNG_ENABLE_EN
        // Test 6: enable gating
        begin
            logic       en_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
            logic [7:0] en_exp [5] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h04};
            reset = 1'b1;
            seed  = 8'h01;
            tick_check("t6_reset");
            reset = 1'b0;
            for (int i = 0; i < 5; i++) begin
                enable = en_pat[i];
                tick_check("t6_model");
                check_value("t6_enable", random_value, en_exp[i]);
            end
            enable = 1'b0;
            reset  = 1'b1;
            #1;
            check_value("t6_reset_override", random_value, 8'h00);
            tick_check("t6_reset_hold");
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
